// File: rtl/main_decoder.sv
// Purpose : main instruction decoder; maps op/funct_5/funct_0 to the 11-bit datapath control word.
// Latency : 0 cycles by default; 1 cycle when MAIN_DECODER_OUTREG_EN is defined (illegal_op is always registered).
// Backpressure: none; pure decode, it never stalls and accepts a new op every cycle.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   op[1:0]               - instruction class (00 DP, 01 memory, 10 branch, 11 undefined)
//   funct_5, funct_0      - I bit (data-processing) and L bit (memory)
//   branch .. alu_op      - datapath controls; imm_src[1:0], reg_src[2:0]
//   illegal_op            - sticky: an op==11 was seen on a clock edge since reset
// Build option: MAIN_DECODER_OUTREG_EN registers the 11 control bits.
module main_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic       funct_5,
  input  logic       funct_0,
  output logic       branch,
  output logic       mem_to_reg,
  output logic       mem_w,
  output logic       alu_src,
  output logic [1:0] imm_src,
  output logic       reg_w,
  output logic [2:0] reg_src,
  output logic       alu_op,
  output logic       illegal_op
);

  // Control word layout, MSB first:
  // {branch, mem_to_reg, mem_w, alu_src, imm_src[1:0], reg_w, reg_src[2:0], alu_op}
  localparam logic [10:0] CW_DP_REG = 11'b0_0_0_0_00_1_100_1;
  localparam logic [10:0] CW_DP_IMM = 11'b0_0_0_1_00_1_000_1;
  localparam logic [10:0] CW_STR    = 11'b0_0_1_1_01_0_010_0;
  localparam logic [10:0] CW_LDR    = 11'b0_1_0_1_01_1_000_0;
  localparam logic [10:0] CW_B      = 11'b1_0_0_1_10_0_001_0;

  logic [10:0] ctrl_d;
  logic [10:0] ctrl_out;
  logic        illegal_op_d;
  logic        illegal_op_q;

  // Undefined op falls through to the all-zero default: no write, no branch.
  always_comb begin
    ctrl_d = '0;
    case (op)
      2'b00:   ctrl_d = funct_5 ? CW_DP_IMM : CW_DP_REG;
      2'b01:   ctrl_d = funct_0 ? CW_LDR : CW_STR;
      2'b10:   ctrl_d = CW_B;
      default: ctrl_d = '0;
    endcase
  end

`ifdef MAIN_DECODER_OUTREG_EN
  logic [10:0] ctrl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ctrl_out = ctrl_q;
`else
  assign ctrl_out = ctrl_d;
`endif

  assign {branch, mem_to_reg, mem_w, alu_src, imm_src, reg_w, reg_src, alu_op} = ctrl_out;

  // Sticky flag: only reset clears it, and reset has priority over op==11.
  always_comb begin
    illegal_op_d = illegal_op_q | (op == 2'b11);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_op_q <= 1'b0;
    end else begin
      illegal_op_q <= illegal_op_d;
    end
  end

  assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_main_decoder.sv
// Testbench for main_decoder: directed literal checks plus randomized traffic
// compared every cycle against a rule-based model of the decode and sticky flag.
module tb_main_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] op = 2'b00;
  logic       funct_5 = 1'b0;
  logic       funct_0 = 1'b0;
  logic       branch, mem_to_reg, mem_w, alu_src, reg_w, alu_op, illegal_op;
  logic [1:0] imm_src;
  logic [2:0] reg_src;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  localparam logic [10:0] L_DPR = 11'b0_0_0_0_00_1_100_1;
  localparam logic [10:0] L_DPI = 11'b0_0_0_1_00_1_000_1;
  localparam logic [10:0] L_STR = 11'b0_0_1_1_01_0_010_0;
  localparam logic [10:0] L_LDR = 11'b0_1_0_1_01_1_000_0;
  localparam logic [10:0] L_B   = 11'b1_0_0_1_10_0_001_0;

  main_decoder dut (
    .clk(clk), .reset(reset), .op(op), .funct_5(funct_5), .funct_0(funct_0),
    .branch(branch), .mem_to_reg(mem_to_reg), .mem_w(mem_w), .alu_src(alu_src),
    .imm_src(imm_src), .reg_w(reg_w), .reg_src(reg_src), .alu_op(alu_op),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  wire [10:0] dut_cw = {branch, mem_to_reg, mem_w, alu_src, imm_src, reg_w, reg_src, alu_op};

  // Model: each control field derived from its meaning in terms of instruction kind.
  function automatic logic [10:0] model_cw(input logic [1:0] o, input logic f5, input logic f0);
    logic dp, dpr, str, ldr, br, legal;
    logic [1:0] imm;
    logic [2:0] rsrc;
    dp    = (o == 2'd0);
    dpr   = dp && !f5;
    str   = (o == 2'd1) && !f0;
    ldr   = (o == 2'd1) && f0;
    br    = (o == 2'd2);
    legal = (o != 2'd3);
    imm   = legal ? o : 2'd0;
    rsrc  = dpr ? 3'd4 : (str ? 3'd2 : (br ? 3'd1 : 3'd0));
    return {br, ldr, str, legal && !dpr, imm, dp || ldr, rsrc, dp};
  endfunction

  logic [10:0] model_ctrl_reg;
  logic        model_ill;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_ill      <= 1'b0;
      model_ctrl_reg <= '0;
    end else begin
      if (op == 2'd3) model_ill <= 1'b1;
      model_ctrl_reg <= model_cw(op, funct_5, funct_0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
`ifdef MAIN_DECODER_OUTREG_EN
      chk("cw_model", {21'd0, dut_cw}, {21'd0, model_ctrl_reg});
`else
      chk("cw_model", {21'd0, dut_cw}, {21'd0, model_cw(op, funct_5, funct_0)});
`endif
      chk("illegal_model", {31'd0, illegal_op}, {31'd0, model_ill});
    end
  end

  // Drive inputs mid-cycle, then check the literal control word after the build's latency.
  task automatic apply(input logic [1:0] o, input logic f5, input logic f0,
                       input logic [10:0] exp, input string name);
    @(posedge clk);
    #2;
    op = o; funct_5 = f5; funct_0 = f0;
`ifdef MAIN_DECODER_OUTREG_EN
    @(posedge clk);
`endif
    #1;
    chk(name, {21'd0, dut_cw}, {21'd0, exp});
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
`ifdef MAIN_DECODER_OUTREG_EN
    chk("reset_cw", {21'd0, dut_cw}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    started = 1'b1;

    // Literal decode table, sweeping don't-care inputs
    for (int f = 0; f < 2; f++) begin
      apply(2'd0, 1'b0, f[0], L_DPR, "dp_reg");
      apply(2'd0, 1'b1, f[0], L_DPI, "dp_imm");
    end
    for (int f = 0; f < 2; f++) begin
      apply(2'd1, f[0], 1'b0, L_STR, "str");
      apply(2'd1, f[0], 1'b1, L_LDR, "ldr");
    end
    for (int f = 0; f < 4; f++) begin
      apply(2'd2, f[1], f[0], L_B, "branch");
    end

`ifdef MAIN_DECODER_OUTREG_EN
    // LDR -> B: output must hold until the next rising edge
    apply(2'd1, 1'b0, 1'b1, L_LDR, "outreg_ldr");
    @(posedge clk);
    #2;
    op = 2'd2;
    #1;
    chk("outreg_hold", {21'd0, dut_cw}, {21'd0, L_LDR});
    @(posedge clk);
    #1;
    chk("outreg_update", {21'd0, dut_cw}, {21'd0, L_B});
`endif

    // Undefined op: zero controls, sticky flag after an edge
    chk("illegal_before", {31'd0, illegal_op}, 32'd0);
    apply(2'd3, 1'b1, 1'b1, 11'd0, "undef_cw");
    @(posedge clk);
    #1;
    chk("illegal_set", {31'd0, illegal_op}, 32'd1);
    chk("undef_cw_hold", {21'd0, dut_cw}, 32'd0);
    apply(2'd0, 1'b0, 1'b0, L_DPR, "dp_after_illegal");
    @(posedge clk);
    #1;
    chk("illegal_sticky", {31'd0, illegal_op}, 32'd1);

    // Mid-cycle reset clears immediately
    #2;
    reset = 1'b1;
    #1;
    chk("illegal_async_clr", {31'd0, illegal_op}, 32'd0);

    // op==11 together with reset: reset wins
    op = 2'd3;
    @(posedge clk);
    #1;
    chk("reset_wins", {31'd0, illegal_op}, 32'd0);
`ifdef MAIN_DECODER_OUTREG_EN
    chk("reset_cw_mid", {21'd0, dut_cw}, 32'd0);
`endif
    #1;
    op = 2'd0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("illegal_after_reset", {31'd0, illegal_op}, 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      op      = 2'($urandom_range(0, 3));
      funct_5 = 1'($urandom_range(0, 1));
      funct_0 = 1'($urandom_range(0, 1));
      reset   = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
